commit_unit: RTL and testbench
==============================

// Module: commit_unit
// PURPOSE
//  Parametrised in-order retirement stage for the multithreaded pipeline; sits after stage_tl.
//  Per thread, commits only the WB entry whose pc equals that thread's expected PC; replays otherwise.
//  Issues regfile writes, TLB writes and fetch redirects.
//  Buffers committed stores in a STQ_DEPTH FIFO drained to the d-cache by valid/ready handshake.
// PARAMETERS
//  N_THREADS  8       hardware threads (>=2, power of 2); TID_W = $clog2(N_THREADS)
//  XLEN       32      data/virtual-address width
//  PADDR_W    20      physical store address width (wb_data[PADDR_W-1:0])
//  PPN_W      8       TLB write ppn width (wb_r2[PPN_W-1:0])
//  STQ_DEPTH  4       store queue entries (power of 2, >=2)
//  RESET_PC   'h1000  boot PC of every thread
// PORTS
//  clk           in   1              clock
//  rst           in   1              async reset, active-high
//  wb_en         in   1              WB entry present this cycle
//  wb_thread     in   TID_W          entry thread
//  wb_pc         in   XLEN           entry PC
//  wb_isvalid    in   1              0 = miss/invalid, needs replay
//  wb_dst        in   5              destination register
//  wb_data       in   XLEN           ALU result / address / jump target / vpn
//  wb_mul        in   XLEN           multiplier result
//  wb_r2         in   XLEN           store data / ppn
//  wb_flags      in   8              {reg,mul,jump,branch,isequal,store,isbyte,iret}
//  wb_tlbwrite   in   2              0 none, 1 itlb, 2 dtlb
//  rf_wen        out  1              regfile write strobe
//  rf_thread     out  TID_W          regfile write thread
//  rf_addr       out  5              regfile write index
//  rf_wdata      out  XLEN           regfile write data
//  redir_en      out  1              fetch redirect pulse
//  redir_thread  out  TID_W          redirect thread
//  redir_pc      out  XLEN           redirect target
//  commit_pc     out  N_THREADS*XLEN  expected PC per thread
//  itlb_wen      out  1              itlb write pulse
//  dtlb_wen      out  1              dtlb write pulse
//  tlb_vpn       out  XLEN-12        wb_data[XLEN-13:0]
//  tlb_ppn       out  PPN_W          TLB write ppn
//  st_valid      out  1              store queue head valid
//  st_ready      in   1              d-cache accepts head
//  st_addr       out  PADDR_W        head address
//  st_data       out  XLEN           head data
//  st_isbyte     out  1              head is byte store
//  stq_full      out  1              count == STQ_DEPTH
// BEHAVIOUR
//  Reset (async): commit_pc[i]=RESET_PC; all pulses, rf_*, redir_*, tlb_* = 0; STQ empty (st_valid=0).
//  Reset discards queued stores; no partial drain.
//  Outputs are registered: 1-cycle latency from wb_en to rf_wen/redir_en/tlb pulses.
//  All strobes are single-cycle; at most one WB entry per cycle.
//  Per-thread FSM:
//   RUN: entry with wb_pc==commit_pc[t] and wb_isvalid=1 and no block -> COMMIT;
//        wb_pc==commit_pc[t], (!wb_isvalid or block) -> redir_en, redir_pc=commit_pc[t], go REPLAY.
//   REPLAY: entries with wb_pc!=commit_pc[t] are dropped silently.
//        Matching valid entry commits and returns to RUN; matching invalid re-redirects, stays REPLAY.
//   RUN, pc mismatch: dropped, no outputs.
//  COMMIT:
//   commit_pc[t] += 4 (mod 2^XLEN, wraps).
//   reg flag -> rf write, data = mul ? wb_mul : wb_data.
//   Taken jump = jump & (!branch | isequal): commit_pc[t]=wb_data, redir_en, redir_pc=wb_data.
//   store flag -> push {wb_data[PADDR_W-1:0], wb_r2, isbyte}.
//   wb_tlbwrite 1/2 -> itlb_wen/dtlb_wen pulse; 3 is ignored.
//  block = store & stq_full. Full is evaluated on the registered count, with no same-cycle pop bypass.
//  STQ: FIFO with wrapping pointers; pop when st_valid & st_ready.
//   Push+pop in one cycle: count unchanged.
//   Head fields stable while st_valid & !st_ready.
//  Other threads are unaffected by one thread's REPLAY.
//  Simultaneous redirect and STQ pop are independent.
// CONFIGURATION
//  COMMIT_PERF_EN defined: adds ports perf_retired and perf_replays (out, N_THREADS*32).
//   Per-thread saturating counters: +1 per commit / per redirect caused by replay; reset 0.
//  COMMIT_PERF_EN undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  1. Reset, thread 2 valid ALU wb_pc=0x1000, reg=1, dst=5, data=7
//     -> next cycle rf_wen, rf_thread=2, rf_addr=5, rf_wdata=7; commit_pc[2]=0x1004.
//  2. Thread 0 wb_pc=0x1000, isvalid=0 -> redir_pc=0x1000; then wb_pc=0x1004 valid -> dropped;
//     then wb_pc=0x1000 valid -> commit.
//  3. Branch, isequal=0 -> commit_pc+4, no redirect.
//     isequal=1, data=0x2000 -> redir_pc=0x2000, commit_pc=0x2000.
//  4. st_ready=0, commit 4 stores -> stq_full=1.
//     5th store -> replay redirect, no push.
//     st_ready=1 -> drains in FIFO order, one per cycle.
//  5. commit_pc=0xFFFFFFFC, valid non-jump -> commit_pc=0.
//     wb_tlbwrite=2, data=0x12345 -> dtlb_wen, tlb_vpn=0x12345.
//  6. Assert rst asynchronously with 3 queued stores, mid-cycle
//     -> st_valid=0 and all commit_pc=0x1000 immediately.

Source files
------------

// File: rtl/commit_unit.sv
// commit_unit: in-order per-thread retirement with replay, redirects, TLB writes and a store queue.
// Optional COMMIT_PERF_EN adds per-thread retired/replay counters.
module commit_unit #(
    parameter int N_THREADS = 8,
    parameter int XLEN = 32,
    parameter int PADDR_W = 20,
    parameter int PPN_W = 8,
    parameter int STQ_DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC = 'h1000
) (
    input  logic clk,
    input  logic rst,
    input  logic wb_en,
    input  logic [$clog2(N_THREADS)-1:0] wb_thread,
    input  logic [XLEN-1:0] wb_pc,
    input  logic wb_isvalid,
    input  logic [4:0] wb_dst,
    input  logic [XLEN-1:0] wb_data,
    input  logic [XLEN-1:0] wb_mul,
    input  logic [XLEN-1:0] wb_r2,
    input  logic [7:0] wb_flags,
    input  logic [1:0] wb_tlbwrite,
    output logic rf_wen,
    output logic [$clog2(N_THREADS)-1:0] rf_thread,
    output logic [4:0] rf_addr,
    output logic [XLEN-1:0] rf_wdata,
    output logic redir_en,
    output logic [$clog2(N_THREADS)-1:0] redir_thread,
    output logic [XLEN-1:0] redir_pc,
    output logic [N_THREADS*XLEN-1:0] commit_pc,
    output logic itlb_wen,
    output logic dtlb_wen,
    output logic [XLEN-13:0] tlb_vpn,
    output logic [PPN_W-1:0] tlb_ppn,
    output logic st_valid,
    input  logic st_ready,
    output logic [PADDR_W-1:0] st_addr,
    output logic [XLEN-1:0] st_data,
    output logic st_isbyte,
    output logic stq_full
`ifdef COMMIT_PERF_EN
    ,
    output logic [N_THREADS*32-1:0] perf_retired,
    output logic [N_THREADS*32-1:0] perf_replays
`endif
);
    localparam int PW = $clog2(STQ_DEPTH);
    localparam int CW = PW + 1;
    typedef enum logic {RUN, REPLAY} state_t;
    state_t state [N_THREADS];
    logic [XLEN-1:0] cpc [N_THREADS];
    logic [PADDR_W-1:0] q_addr [STQ_DEPTH];
    logic [XLEN-1:0] q_data [STQ_DEPTH];
    logic q_byte [STQ_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic f_reg, f_mul, f_jump, f_branch, f_iseq, f_store, f_byte, unused_iret;
    logic match, block, commit, replay, taken, push, pop;
    assign {f_reg, f_mul, f_jump, f_branch, f_iseq, f_store, f_byte, unused_iret} = wb_flags;
    assign match = wb_en && wb_pc == cpc[wb_thread];
    // a full queue is judged on the registered count, so a same-cycle drain does not unblock
    assign block = f_store && stq_full;
    assign commit = match && wb_isvalid && !block;
    assign replay = match && !(wb_isvalid && !block);
    assign taken = f_jump && (!f_branch || f_iseq);
    assign push = commit && f_store;
    assign pop = st_valid && st_ready;
    assign stq_full = count == CW'(STQ_DEPTH);
    assign st_valid = count != '0;
    assign st_addr = q_addr[rd_ptr];
    assign st_data = q_data[rd_ptr];
    assign st_isbyte = q_byte[rd_ptr];
    for (genvar i = 0; i < N_THREADS; i++) begin : g_pc
        assign commit_pc[i*XLEN +: XLEN] = cpc[i];
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_THREADS; i++) begin
                cpc[i] <= RESET_PC;
                state[i] <= RUN;
            end
            rf_wen <= 1'b0;
            rf_thread <= '0;
            rf_addr <= '0;
            rf_wdata <= '0;
            redir_en <= 1'b0;
            redir_thread <= '0;
            redir_pc <= '0;
            itlb_wen <= 1'b0;
            dtlb_wen <= 1'b0;
            tlb_vpn <= '0;
            tlb_ppn <= '0;
        end else begin
            rf_wen <= 1'b0;
            redir_en <= 1'b0;
            itlb_wen <= 1'b0;
            dtlb_wen <= 1'b0;
            if (commit) begin
                state[wb_thread] <= RUN;
                cpc[wb_thread] <= taken ? wb_data : cpc[wb_thread] + XLEN'(4);
                rf_wen <= f_reg;
                if (f_reg) begin
                    rf_thread <= wb_thread;
                    rf_addr <= wb_dst;
                    rf_wdata <= f_mul ? wb_mul : wb_data;
                end
                if (taken) begin
                    redir_en <= 1'b1;
                    redir_thread <= wb_thread;
                    redir_pc <= wb_data;
                end
                itlb_wen <= wb_tlbwrite == 2'd1;
                dtlb_wen <= wb_tlbwrite == 2'd2;
                if (wb_tlbwrite == 2'd1 || wb_tlbwrite == 2'd2) begin
                    tlb_vpn <= wb_data[XLEN-13:0];
                    tlb_ppn <= wb_r2[PPN_W-1:0];
                end
            end else if (replay) begin
                state[wb_thread] <= REPLAY;
                redir_en <= 1'b1;
                redir_thread <= wb_thread;
                redir_pc <= cpc[wb_thread];
            end
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(push);
            rd_ptr <= rd_ptr + PW'(pop);
            count <= count + CW'(push) - CW'(pop);
        end
    end
    always_ff @(posedge clk) begin
        if (push) begin
            q_addr[wr_ptr] <= wb_data[PADDR_W-1:0];
            q_data[wr_ptr] <= wb_r2;
            q_byte[wr_ptr] <= f_byte;
        end
    end
`ifdef COMMIT_PERF_EN
    logic [31:0] ret_cnt [N_THREADS];
    logic [31:0] rep_cnt [N_THREADS];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_THREADS; i++) begin
                ret_cnt[i] <= '0;
                rep_cnt[i] <= '0;
            end
        end else begin
            if (commit && ret_cnt[wb_thread] != '1) ret_cnt[wb_thread] <= ret_cnt[wb_thread] + 32'd1;
            if (replay && rep_cnt[wb_thread] != '1) rep_cnt[wb_thread] <= rep_cnt[wb_thread] + 32'd1;
        end
    end
    for (genvar i = 0; i < N_THREADS; i++) begin : g_perf
        assign perf_retired[i*32 +: 32] = ret_cnt[i];
        assign perf_replays[i*32 +: 32] = rep_cnt[i];
    end
`endif
endmodule

// File: tb/tb_commit_unit.sv
// tb_commit_unit: directed scenario tests for commit_unit with default parameters.
module tb_commit_unit;
    logic clk, rst, wb_en, wb_isvalid, st_ready;
    logic [2:0] wb_thread;
    logic [31:0] wb_pc, wb_data, wb_mul, wb_r2;
    logic [4:0] wb_dst;
    logic [7:0] wb_flags;
    logic [1:0] wb_tlbwrite;
    logic rf_wen, redir_en, itlb_wen, dtlb_wen, st_valid, st_isbyte, stq_full;
    logic [2:0] rf_thread, redir_thread;
    logic [4:0] rf_addr;
    logic [31:0] rf_wdata, redir_pc, st_data;
    logic [255:0] commit_pc;
    logic [19:0] tlb_vpn, st_addr;
    logic [7:0] tlb_ppn;
    int checks = 0;
    int failures = 0;

    commit_unit dut (
        .clk(clk), .rst(rst), .wb_en(wb_en), .wb_thread(wb_thread), .wb_pc(wb_pc),
        .wb_isvalid(wb_isvalid), .wb_dst(wb_dst), .wb_data(wb_data), .wb_mul(wb_mul),
        .wb_r2(wb_r2), .wb_flags(wb_flags), .wb_tlbwrite(wb_tlbwrite),
        .rf_wen(rf_wen), .rf_thread(rf_thread), .rf_addr(rf_addr), .rf_wdata(rf_wdata),
        .redir_en(redir_en), .redir_thread(redir_thread), .redir_pc(redir_pc),
        .commit_pc(commit_pc), .itlb_wen(itlb_wen), .dtlb_wen(dtlb_wen),
        .tlb_vpn(tlb_vpn), .tlb_ppn(tlb_ppn), .st_valid(st_valid), .st_ready(st_ready),
        .st_addr(st_addr), .st_data(st_data), .st_isbyte(st_isbyte), .stq_full(stq_full)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    function automatic logic [31:0] cp(input int t);
        return commit_pc[t*32 +: 32];
    endfunction

    // present one WB entry for a single cycle; outputs are valid on return
    task automatic wb(input int t, input logic [31:0] pc, input logic v, input logic [7:0] fl,
                      input logic [4:0] dst, input logic [31:0] data, input logic [31:0] mul,
                      input logic [31:0] r2, input logic [1:0] tw);
        wb_en = 1; wb_thread = 3'(t); wb_pc = pc; wb_isvalid = v; wb_flags = fl;
        wb_dst = dst; wb_data = data; wb_mul = mul; wb_r2 = r2; wb_tlbwrite = tw;
        @(posedge clk); #1;
        wb_en = 0;
    endtask

    task automatic test_reset;
        rst = 1; wb_en = 0; st_ready = 0; wb_thread = 0; wb_pc = 0; wb_isvalid = 0;
        wb_dst = 0; wb_data = 0; wb_mul = 0; wb_r2 = 0; wb_flags = 0; wb_tlbwrite = 0;
        repeat (2) @(posedge clk);
        #1;
        for (int t = 0; t < 8; t++) begin
            checks++; if (cp(t) !== 32'h1000) begin failures++; $display("FAIL reset_pc%0d got=%h exp=00001000", t, cp(t)); end
        end
        checks++; if ({rf_wen, redir_en, itlb_wen, dtlb_wen, st_valid, stq_full} !== 6'b0) begin failures++; $display("FAIL reset_strobes got=%b exp=000000", {rf_wen, redir_en, itlb_wen, dtlb_wen, st_valid, stq_full}); end
        rst = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_alu;
        wb(2, 32'h1000, 1, 8'h80, 5, 7, 0, 0, 0);
        checks++; if (rf_wen !== 1) begin failures++; $display("FAIL alu_rf_wen got=%b exp=1", rf_wen); end
        checks++; if (rf_thread !== 2) begin failures++; $display("FAIL alu_rf_thread got=%0d exp=2", rf_thread); end
        checks++; if (rf_addr !== 5) begin failures++; $display("FAIL alu_rf_addr got=%0d exp=5", rf_addr); end
        checks++; if (rf_wdata !== 7) begin failures++; $display("FAIL alu_rf_wdata got=%h exp=7", rf_wdata); end
        checks++; if (cp(2) !== 32'h1004) begin failures++; $display("FAIL alu_pc got=%h exp=00001004", cp(2)); end
        checks++; if (redir_en !== 0) begin failures++; $display("FAIL alu_redir got=%b exp=0", redir_en); end
        wb(2, 32'h1004, 1, 8'hC0, 9, 7, 32'h55, 0, 0);
        checks++; if (rf_wdata !== 32'h55 || rf_addr !== 9) begin failures++; $display("FAIL mul_rf got=%h/%0d exp=55/9", rf_wdata, rf_addr); end
        checks++; if (cp(2) !== 32'h1008) begin failures++; $display("FAIL mul_pc got=%h exp=00001008", cp(2)); end
        @(posedge clk); #1;
        checks++; if (rf_wen !== 0) begin failures++; $display("FAIL rf_pulse got=%b exp=0", rf_wen); end
    endtask

    task automatic test_replay;
        wb(0, 32'h1000, 0, 8'h80, 3, 9, 0, 0, 0);
        checks++; if (redir_en !== 1 || redir_thread !== 0 || redir_pc !== 32'h1000) begin failures++; $display("FAIL replay_redir got=%b/%0d/%h exp=1/0/00001000", redir_en, redir_thread, redir_pc); end
        checks++; if (rf_wen !== 0 || cp(0) !== 32'h1000) begin failures++; $display("FAIL replay_nocommit got=%b/%h exp=0/00001000", rf_wen, cp(0)); end
        wb(0, 32'h1004, 1, 8'h80, 3, 9, 0, 0, 0);
        checks++; if (rf_wen !== 0 || redir_en !== 0 || cp(0) !== 32'h1000) begin failures++; $display("FAIL replay_drop got=%b/%b/%h exp=0/0/00001000", rf_wen, redir_en, cp(0)); end
        wb(1, 32'h1000, 1, 8'h80, 4, 11, 0, 0, 0);
        checks++; if (rf_wen !== 1 || rf_thread !== 1 || cp(1) !== 32'h1004) begin failures++; $display("FAIL other_thread got=%b/%0d/%h exp=1/1/00001004", rf_wen, rf_thread, cp(1)); end
        wb(0, 32'h1000, 1, 8'h80, 3, 9, 0, 0, 0);
        checks++; if (rf_wen !== 1 || rf_addr !== 3 || rf_wdata !== 9) begin failures++; $display("FAIL replay_commit got=%b/%0d/%h exp=1/3/9", rf_wen, rf_addr, rf_wdata); end
        checks++; if (cp(0) !== 32'h1004) begin failures++; $display("FAIL replay_pc got=%h exp=00001004", cp(0)); end
        wb(0, 32'h1000, 1, 8'h80, 3, 9, 0, 0, 0);
        checks++; if (rf_wen !== 0 || redir_en !== 0) begin failures++; $display("FAIL run_mismatch got=%b/%b exp=0/0", rf_wen, redir_en); end
    endtask

    task automatic test_branch;
        wb(3, 32'h1000, 1, 8'h30, 0, 32'h2000, 0, 0, 0);
        checks++; if (redir_en !== 0 || cp(3) !== 32'h1004) begin failures++; $display("FAIL br_nottaken got=%b/%h exp=0/00001004", redir_en, cp(3)); end
        wb(3, 32'h1004, 1, 8'h38, 0, 32'h2000, 0, 0, 0);
        checks++; if (redir_en !== 1 || redir_thread !== 3 || redir_pc !== 32'h2000) begin failures++; $display("FAIL br_taken got=%b/%0d/%h exp=1/3/00002000", redir_en, redir_thread, redir_pc); end
        checks++; if (cp(3) !== 32'h2000) begin failures++; $display("FAIL br_pc got=%h exp=00002000", cp(3)); end
    endtask

    task automatic test_store;
        st_ready = 0;
        for (int k = 0; k < 4; k++)
            wb(4, 32'h1000 + 32'(4*k), 1, (k == 1) ? 8'h06 : 8'h04, 0, 32'hFFF00100 + 32'(k), 0, 32'hD000 + 32'(k), 0);
        checks++; if (stq_full !== 1 || st_valid !== 1) begin failures++; $display("FAIL stq_full got=%b/%b exp=1/1", stq_full, st_valid); end
        wb(4, 32'h1010, 1, 8'h04, 0, 32'hFFF00200, 0, 32'hBEEF, 0);
        checks++; if (redir_en !== 1 || redir_pc !== 32'h1010 || cp(4) !== 32'h1010) begin failures++; $display("FAIL stq_block got=%b/%h/%h exp=1/00001010/00001010", redir_en, redir_pc, cp(4)); end
        st_ready = 1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (st_valid !== 1 || st_addr !== 20'h00100 + 20'(k) || st_data !== 32'hD000 + 32'(k) || st_isbyte !== (k == 1)) begin
                failures++; $display("FAIL drain%0d got=%b/%h/%h/%b exp=1/%h/%h/%b", k, st_valid, st_addr, st_data, st_isbyte, 20'h00100 + 20'(k), 32'hD000 + 32'(k), k == 1);
            end
            @(posedge clk); #1;
        end
        checks++; if (st_valid !== 0 || stq_full !== 0) begin failures++; $display("FAIL drain_empty got=%b/%b exp=0/0", st_valid, stq_full); end
        st_ready = 0;
    endtask

    task automatic test_wrap_tlb;
        wb(5, 32'h1000, 1, 8'h20, 0, 32'hFFFFFFFC, 0, 0, 0);
        checks++; if (cp(5) !== 32'hFFFFFFFC || redir_pc !== 32'hFFFFFFFC) begin failures++; $display("FAIL jump got=%h/%h exp=fffffffc", cp(5), redir_pc); end
        wb(5, 32'hFFFFFFFC, 1, 8'h00, 0, 0, 0, 0, 0);
        checks++; if (cp(5) !== 0) begin failures++; $display("FAIL pc_wrap got=%h exp=00000000", cp(5)); end
        wb(5, 0, 1, 8'h00, 0, 32'h12345, 0, 32'hAB, 2);
        checks++; if (dtlb_wen !== 1 || itlb_wen !== 0 || tlb_vpn !== 20'h12345 || tlb_ppn !== 8'hAB) begin failures++; $display("FAIL dtlb got=%b/%b/%h/%h exp=1/0/12345/ab", dtlb_wen, itlb_wen, tlb_vpn, tlb_ppn); end
        wb(5, 4, 1, 8'h00, 0, 32'h00777, 0, 32'h11, 1);
        checks++; if (itlb_wen !== 1 || dtlb_wen !== 0 || tlb_vpn !== 20'h00777) begin failures++; $display("FAIL itlb got=%b/%b/%h exp=1/0/00777", itlb_wen, dtlb_wen, tlb_vpn); end
        wb(5, 8, 1, 8'h00, 0, 32'h00999, 0, 0, 3);
        checks++; if (itlb_wen !== 0 || dtlb_wen !== 0 || cp(5) !== 32'hC) begin failures++; $display("FAIL tlb3 got=%b/%b/%h exp=0/0/0000000c", itlb_wen, dtlb_wen, cp(5)); end
    endtask

    task automatic test_async_reset;
        for (int k = 0; k < 3; k++)
            wb(6, 32'h1000 + 32'(4*k), 1, 8'h04, 0, 32'h300 + 32'(k), 0, 32'(k), 0);
        checks++; if (st_valid !== 1 || cp(6) !== 32'h100C) begin failures++; $display("FAIL pre_rst got=%b/%h exp=1/0000100c", st_valid, cp(6)); end
        #2 rst = 1;
        #1;
        checks++; if (st_valid !== 0 || stq_full !== 0) begin failures++; $display("FAIL arst_stq got=%b/%b exp=0/0", st_valid, stq_full); end
        for (int t = 0; t < 8; t++) begin
            checks++; if (cp(t) !== 32'h1000) begin failures++; $display("FAIL arst_pc%0d got=%h exp=00001000", t, cp(t)); end
        end
        @(negedge clk) rst = 0;
        @(posedge clk); #1;
        wb(6, 32'h1000, 1, 8'h80, 1, 32'h42, 0, 0, 0);
        checks++; if (rf_wen !== 1 || cp(6) !== 32'h1004 || st_valid !== 0) begin failures++; $display("FAIL post_rst got=%b/%h/%b exp=1/00001004/0", rf_wen, cp(6), st_valid); end
    endtask

    initial begin
        test_reset;
        test_alu;
        test_replay;
        test_branch;
        test_store;
        test_wrap_tlb;
        test_async_reset;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
